uart_tx_scheduler: RTL and testbench

Shares the single UART transmitter between two byte sources: the receive echo path and the 16-bit word-send path. The block buffers echoed bytes in a small FIFO and splits words into low-then-high byte pairs. It round-robins between the two sources and drives the transmitter through a level request/busy handshake. It sits between the receiver/user logic and the transmitter, replacing ad-hoc enable generation.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_scheduler.sv | 158 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Covers the FSM state encoding, the grant encoding and the byte width.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_ECHO = 1'b0,
        GRANT_WORD = 1'b1
    } grant_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO. The read data comes straight from the storage registers.
// A push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             drop,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between the echo FIFO and the 16-bit word path.
// Round-robin grant; a word goes out low byte then high byte with no echo in between.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int ECHO_DEPTH = 4,
    parameter int CW         = $clog2(ECHO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic [15:0]   word_data,
    input  logic          word_valid,
    output logic          word_ready,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy,
    output logic [CW-1:0] echo_count,
    output logic          echo_overflow,
    output logic [7:0]    last_byte
);
    state_e              state_q, state_d;
    grant_e              last_grant_q, last_grant_d;
    logic                tx_start_q, tx_start_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic [BYTE_W-1:0]   last_byte_q, last_byte_d;
    logic                phase_q, phase_d;
    logic                hi_q, hi_d;
    logic                word_full_q, word_full_d;
    logic [15:0]         word_q, word_d;
    logic                overflow_q, overflow_d;

    logic                fifo_pop, fifo_empty, fifo_full, fifo_drop;
    logic [BYTE_W-1:0]   fifo_rd;
    logic                echo_pend, word_pend, grant_word;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (ECHO_DEPTH),
        .CW    (CW)
    ) u_echo_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (rx_valid),
        .wr_data (rx_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .drop    (fifo_drop),
        .count   (echo_count)
    );

    assign echo_pend  = !fifo_empty;
    assign word_pend  = word_full_q;
    assign grant_word = word_pend && (!echo_pend || (last_grant_q == GRANT_ECHO));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tx_start_d   = tx_start_q;
        tx_data_d    = tx_data_q;
        last_byte_d  = last_byte_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        word_full_d  = word_full_q;
        word_d       = word_q;
        overflow_d   = overflow_q | fifo_drop;
        fifo_pop     = 1'b0;

        if (word_valid && !word_full_q) begin
            word_full_d = 1'b1;
            word_d      = word_data;
        end

        case (state_q)
            ST_IDLE: begin
                // tx_busy here may be a leftover frame from before reset; just wait it out
                if (!tx_busy && (echo_pend || word_pend)) begin
                    if (grant_word) begin
                        tx_data_d    = word_q[7:0];
                        phase_d      = 1'b1;
                        last_grant_d = GRANT_WORD;
                    end else begin
                        tx_data_d    = fifo_rd;
                        fifo_pop     = 1'b1;
                        last_grant_d = GRANT_ECHO;
                    end
                    last_byte_d = tx_data_d;
                    tx_start_d  = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (phase_q) begin
                        tx_data_d   = word_q[15:8];
                        last_byte_d = word_q[15:8];
                        phase_d     = 1'b0;
                        hi_d        = 1'b1;
                        tx_start_d  = 1'b1;
                        state_d     = ST_REQ;
                    end else begin
                        if (hi_q) begin
                            word_full_d = 1'b0;
                            hi_d        = 1'b0;
                        end
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_WORD;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            last_byte_q  <= '0;
            phase_q      <= 1'b0;
            hi_q         <= 1'b0;
            word_full_q  <= 1'b0;
            word_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            last_byte_q  <= last_byte_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            word_full_q  <= word_full_d;
            word_q       <= word_d;
            overflow_q   <= overflow_d;
        end
    end

    assign tx_start      = tx_start_q;
    assign tx_data       = tx_data_q;
    assign last_byte     = last_byte_q;
    assign word_ready    = !word_full_q;
    assign echo_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a cycle table for echo and word split,
// then hand sequences for arbitration, overflow and reset mid-frame.
module tb_uart_tx_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [2:0]  echo_count;
    logic        echo_overflow;
    logic [7:0]  last_byte;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_scheduler #(.ECHO_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .echo_count    (echo_count),
        .echo_overflow (echo_overflow),
        .last_byte     (last_byte)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rx_v;
        logic [7:0]  rx_d;
        logic        wv;
        logic [15:0] wd;
        logic        busy;
        logic        e_start;
        logic [7:0]  e_data;
        logic        e_ready;
        logic [2:0]  e_cnt;
        logic        e_ovf;
        logic [7:0]  e_last;
    } vec_t;

    vec_t vecs [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // wait (bounded) for a start, check the byte, then play one transmitter frame
    task automatic expect_byte(input logic [7:0] b, input string nm);
        int n = 0;
        while (!tx_start && n < 20) begin
            step();
            n++;
        end
        if (!tx_start) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no tx_start expected byte %0h", nm, b);
        end else begin
            chk(nm, {24'h0, tx_data}, {24'h0, b});
        end
        tx_busy = 1'b1;
        step();
        chk({nm, " start drop"}, {31'h0, tx_start}, 32'h0);
        step();
        tx_busy = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; rx_data = '0; rx_valid = 1'b0;
        word_data = '0; word_valid = 1'b0; tx_busy = 1'b0;

        //          rx_v  rx_d   wv    wd        busy  start data   ready cnt   ovf   last
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h41, 1'b1, 3'd0, 1'b0, 8'h41};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h41, 1'b1, 3'd0, 1'b0, 8'h41};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h41, 1'b1, 3'd0, 1'b0, 8'h41};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h41, 1'b1, 3'd0, 1'b0, 8'h41};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h41, 1'b1, 3'd0, 1'b0, 8'h41};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h41, 1'b0, 3'd0, 1'b0, 8'h41};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hEF, 1'b0, 3'd0, 1'b0, 8'hEF};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'hEF, 1'b0, 3'd0, 1'b0, 8'hEF};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hBE, 1'b0, 3'd0, 1'b0, 8'hBE};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'hBE, 1'b0, 3'd0, 1'b0, 8'hBE};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'hBE, 1'b1, 3'd0, 1'b0, 8'hBE};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'hBE, 1'b1, 3'd0, 1'b0, 8'hBE};

        step(); step();
        reset = 1'b0;
        chk("rst tx_start",  {31'h0, tx_start},      32'h0);
        chk("rst tx_data",   {24'h0, tx_data},       32'h0);
        chk("rst last_byte", {24'h0, last_byte},     32'h0);
        chk("rst count",     {29'h0, echo_count},    32'h0);
        chk("rst overflow",  {31'h0, echo_overflow}, 32'h0);
        chk("rst ready",     {31'h0, word_ready},    32'h1);

        // single echo and word split, cycle by cycle
        for (int i = 0; i < 13; i++) begin
            rx_valid = vecs[i].rx_v; rx_data = vecs[i].rx_d;
            word_valid = vecs[i].wv; word_data = vecs[i].wd;
            tx_busy = vecs[i].busy;
            step();
            chk($sformatf("vec%0d start", i), {31'h0, tx_start},      {31'h0, vecs[i].e_start});
            chk($sformatf("vec%0d data", i),  {24'h0, tx_data},       {24'h0, vecs[i].e_data});
            chk($sformatf("vec%0d ready", i), {31'h0, word_ready},    {31'h0, vecs[i].e_ready});
            chk($sformatf("vec%0d count", i), {29'h0, echo_count},    {29'h0, vecs[i].e_cnt});
            chk($sformatf("vec%0d ovf", i),   {31'h0, echo_overflow}, {31'h0, vecs[i].e_ovf});
            chk($sformatf("vec%0d last", i),  {24'h0, last_byte},     {24'h0, vecs[i].e_last});
        end

        // tie with last grant = word: echo first
        rx_valid = 1'b1; rx_data = 8'h55; word_valid = 1'b1; word_data = 16'h1234;
        step();
        rx_valid = 1'b0; word_valid = 1'b0;
        expect_byte(8'h55, "tie1 b0");
        expect_byte(8'h34, "tie1 b1");
        expect_byte(8'h12, "tie1 b2");
        chk("tie1 ready", {31'h0, word_ready}, 32'h1);

        // overflow: five pushes into a depth-4 FIFO while the transmitter is busy
        tx_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i);
            step();
        end
        rx_valid = 1'b0;
        chk("ovf count", {29'h0, echo_count},    32'h4);
        chk("ovf flag",  {31'h0, echo_overflow}, 32'h1);
        chk("ovf no start", {31'h0, tx_start},   32'h0);
        tx_busy = 1'b0;
        for (int i = 1; i <= 4; i++) expect_byte(8'(i), $sformatf("ovf b%0d", i));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ovf drained start", {31'h0, tx_start}, 32'h0);
        end
        chk("ovf drained count", {29'h0, echo_count}, 32'h0);

        // push while full, same cycle as a pop
        tx_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            rx_valid = 1'b1; rx_data = 8'hA0 + 8'(i);
            step();
        end
        rx_valid = 1'b0;
        chk("full count", {29'h0, echo_count}, 32'h4);
        tx_busy = 1'b0; rx_valid = 1'b1; rx_data = 8'hA5;
        step();
        rx_valid = 1'b0;
        chk("popush start", {31'h0, tx_start},   32'h1);
        chk("popush data",  {24'h0, tx_data},    32'hA1);
        chk("popush count", {29'h0, echo_count}, 32'h4);
        for (int i = 1; i <= 5; i++) expect_byte(8'hA0 + 8'(i), $sformatf("popush b%0d", i));
        chk("ovf sticky", {31'h0, echo_overflow}, 32'h1);

        // tie with last grant = echo: word first
        rx_valid = 1'b1; rx_data = 8'h66; word_valid = 1'b1; word_data = 16'hABCD;
        step();
        rx_valid = 1'b0; word_valid = 1'b0;
        expect_byte(8'hCD, "tie2 b0");
        expect_byte(8'hAB, "tie2 b1");
        expect_byte(8'h66, "tie2 b2");

        // reset while a frame is in flight
        rx_valid = 1'b1; rx_data = 8'h11;
        step();
        rx_valid = 1'b0;
        step();
        chk("mid start", {31'h0, tx_start}, 32'h1);
        chk("mid data",  {24'h0, tx_data},  32'h11);
        tx_busy = 1'b1;
        step();
        rx_valid = 1'b1; rx_data = 8'h22; word_valid = 1'b1; word_data = 16'h3344;
        step();
        rx_valid = 1'b0; word_valid = 1'b0;
        chk("mid count", {29'h0, echo_count}, 32'h1);
        chk("mid ready", {31'h0, word_ready}, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst start", {31'h0, tx_start},      32'h0);
        chk("mrst count", {29'h0, echo_count},    32'h0);
        chk("mrst ready", {31'h0, word_ready},    32'h1);
        chk("mrst ovf",   {31'h0, echo_overflow}, 32'h0);
        rx_valid = 1'b1; rx_data = 8'h7A;
        step();
        rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mrst hold start", {31'h0, tx_start}, 32'h0);
            step();
        end
        tx_busy = 1'b0;
        expect_byte(8'h7A, "mrst 7A");
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mrst flushed start", {31'h0, tx_start}, 32'h0);
        end
        chk("mrst last_byte", {24'h0, last_byte}, 32'h7A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
